// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequencing controller for the multicycle MIPS datapath
module multicycle_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             Branch,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSource   = 2'b00;
        illegal_op = 1'b0;
        state_d    = FETCH;
        cnt_d      = cnt_q + CNT_W'(state_q == FETCH && mem_ready);
        case (state_q)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                Branch   = 1'b1;
                PCSource = 2'b01;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: RegWrite = 1'b1;
            default: ;
        endcase
    end
    assign state       = state_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: table, directed and random checks of the multicycle controller
module tb_multicycle_control_fsm;
    localparam int CNT_W = 4;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    typedef struct packed {
        logic       pcw, br, iord, mr, mw, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        logic       ill;
    } out_t;

    typedef struct {
        logic [5:0]  op;
        int          n;
        logic [23:0] path;
    } vec_t;

    logic clk, reset, mem_ready;
    logic [5:0] opcode;
    logic PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic [CNT_W-1:0] instr_count;
    out_t act;
    int total = 0;
    int bad = 0;
    int cnt_m = 0;
    vec_t tbl[7];
    logic [5:0] pool[7];

    multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    assign act = {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic is_legal(logic [5:0] op);
        return op inside {RT, LW, SW, BEQ, JMP, ADDI};
    endfunction

    function automatic out_t exp_out(int st, logic mr, logic [5:0] op);
        out_t e = '0;
        case (st)
            0:  begin e.mr = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
            1:  begin e.asb = 2'b11; e.ill = !is_legal(op); end
            2:  begin e.asa = 1; e.asb = 2'b10; end
            3:  begin e.mr = 1; e.iord = 1; end
            4:  begin e.m2r = 1; e.rw = 1; end
            5:  begin e.mw = 1; e.iord = 1; end
            6:  begin e.asa = 1; e.aop = 2'b10; end
            7:  begin e.rdst = 1; e.rw = 1; end
            8:  begin e.asa = 1; e.aop = 2'b01; e.br = 1; e.pcs = 2'b01; end
            9:  begin e.pcw = 1; e.pcs = 2'b10; end
            10: begin e.asa = 1; e.asb = 2'b10; end
            11: e.rw = 1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, a, e);
        end
    endtask

    task automatic cycle(logic rst, logic mr, logic [5:0] op, int st);
        @(negedge clk);
        reset = rst;
        mem_ready = mr;
        opcode = op;
        #1;
        chk("state", 32'(state), 32'(st));
        chk("outputs", 32'(act), 32'(exp_out(st, mr, op)));
        chk("instr_count", 32'(instr_count), 32'(cnt_m));
        chk("exclusive_writes", 32'($countones({RegWrite, MemWrite, PCWrite}) <= 1), 32'd1);
        if (rst) cnt_m = 0;
        else if (st == 0 && mr) cnt_m = (cnt_m + 1) % (1 << CNT_W);
    endtask

    task automatic run_instr(logic [5:0] op, int fw, int mw);
        int ms;
        for (int i = 0; i < fw; i++) cycle(0, 0, 6'($urandom), 0);
        cycle(0, 1, 6'($urandom), 0);
        cycle(0, 1'($urandom), op, 1);
        if (op == LW || op == SW) begin
            ms = (op == SW) ? 5 : 3;
            cycle(0, 1'($urandom), op, 2);
            for (int i = 0; i < mw; i++) cycle(0, 0, op, ms);
            cycle(0, 1, op, ms);
            if (op == LW) cycle(0, 1'($urandom), op, 4);
        end else if (op == RT) begin
            cycle(0, 1'($urandom), op, 6);
            cycle(0, 1'($urandom), op, 7);
        end else if (op == BEQ) begin
            cycle(0, 1'($urandom), op, 8);
        end else if (op == JMP) begin
            cycle(0, 1'($urandom), op, 9);
        end else if (op == ADDI) begin
            cycle(0, 1'($urandom), op, 10);
            cycle(0, 1'($urandom), op, 11);
        end
    endtask

    initial begin
        tbl[0] = '{RT,   4, 24'h016700};
        tbl[1] = '{BEQ,  3, 24'h018000};
        tbl[2] = '{JMP,  3, 24'h019000};
        tbl[3] = '{ADDI, 4, 24'h01AB00};
        tbl[4] = '{LW,   5, 24'h012340};
        tbl[5] = '{SW,   4, 24'h012500};
        tbl[6] = '{BAD,  2, 24'h010000};
        pool = '{RT, LW, SW, BEQ, JMP, ADDI, BAD};
        reset = 1'b1;
        mem_ready = 1'b0;
        opcode = 6'd0;
        repeat (2) @(posedge clk);
        cycle(1, 0, RT, 0);
        for (int t = 0; t < 7; t++)
            for (int i = 0; i < tbl[t].n; i++)
                cycle(0, 1, tbl[t].op, int'(tbl[t].path[23 - 4*i -: 4]));
        cycle(0, 1, LW, 0);
        cycle(0, 1, LW, 1);
        cycle(0, 1, LW, 2);
        cycle(0, 0, LW, 3);
        cycle(1, 1, LW, 3);
        cycle(1, 1, LW, 0);
        cycle(0, 0, LW, 0);
        run_instr(SW, 0, 3);
        run_instr(BAD, 0, 0);
        for (int i = 0; i < 16; i++) run_instr(JMP, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 6'($urandom), 0);
        for (int i = 0; i < 80; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : pool[$urandom_range(0, 6)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        cycle(0, 0, RT, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
